// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin arbiter and burst sequencer between I$/D$ and main memory
module cache_mem_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          REQ0,
    input  logic                          REQ1,
    input  logic                          WE0,
    input  logic                          WE1,
    input  logic [ADDR_W-1:0]             ADDR0,
    input  logic [ADDR_W-1:0]             ADDR1,
    input  logic [DATA_W-1:0]             WDATA0,
    input  logic [DATA_W-1:0]             WDATA1,
    output logic                          GNT0,
    output logic                          GNT1,
    output logic [DATA_W-1:0]             RDATA,
    output logic                          RVALID0,
    output logic                          RVALID1,
    output logic [$clog2(LINE_WORDS)-1:0] WIDX,
    output logic                          DONE0,
    output logic                          DONE1,
    output logic                          MEM_REQ,
    output logic                          MEM_WE,
    output logic [ADDR_W-1:0]             MEM_ADDR,
    output logic [DATA_W-1:0]             MEM_WDATA,
    input  logic [DATA_W-1:0]             MEM_RDATA,
    input  logic                          MEM_ACK
);
    localparam int BW   = $clog2(LINE_WORDS);
    localparam int OFFS = BW + 2;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFFS) - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;

    state_t          state;
    logic [BW-1:0]   beat;
    logic            last;
    logic            owner;
    logic            pick;
    logic            sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // On a tie the port not served last wins; a lone requester always wins.
    always_comb begin
        pick      = (REQ0 && REQ1) ? ~last : REQ1;
        sel_we    = pick ? WE1 : WE0;
        sel_addr  = pick ? ADDR1 : ADDR0;
        sel_wdata = pick ? WDATA1 : WDATA0;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            beat      <= '0;
            last      <= 1'b1;
            owner     <= 1'b0;
            GNT0      <= 1'b0;
            GNT1      <= 1'b0;
            RDATA     <= '0;
            RVALID0   <= 1'b0;
            RVALID1   <= 1'b0;
            WIDX      <= '0;
            DONE0     <= 1'b0;
            DONE1     <= 1'b0;
            MEM_REQ   <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
        end else begin
            RVALID0 <= 1'b0;
            RVALID1 <= 1'b0;
            DONE0   <= 1'b0;
            DONE1   <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ0 || REQ1) begin
                        owner   <= pick;
                        last    <= pick;
                        GNT0    <= ~pick;
                        GNT1    <= pick;
                        MEM_REQ <= 1'b1;
                        if (sel_we) begin
                            state     <= WRITE;
                            MEM_WE    <= 1'b1;
                            MEM_ADDR  <= sel_addr & WORD_MASK;
                            MEM_WDATA <= sel_wdata;
                        end else begin
                            state    <= READ;
                            MEM_WE   <= 1'b0;
                            MEM_ADDR <= sel_addr & LINE_MASK;
                        end
                    end
                end
                READ: begin
                    if (MEM_ACK) begin
                        RDATA    <= MEM_RDATA;
                        WIDX     <= beat;
                        RVALID0  <= ~owner;
                        RVALID1  <= owner;
                        MEM_ADDR <= MEM_ADDR + ADDR_W'(4);
                        if (beat == BW'(LINE_WORDS - 1)) begin
                            // Completion is signalled together with the final word.
                            state   <= FINISH;
                            DONE0   <= ~owner;
                            DONE1   <= owner;
                            GNT0    <= 1'b0;
                            GNT1    <= 1'b0;
                            MEM_REQ <= 1'b0;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (MEM_ACK) begin
                        state   <= FINISH;
                        DONE0   <= ~owner;
                        DONE1   <= owner;
                        GNT0    <= 1'b0;
                        GNT1    <= 1'b0;
                        MEM_REQ <= 1'b0;
                        MEM_WE  <= 1'b0;
                    end
                end
                FINISH: begin
                    beat  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - scoreboard bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
    localparam int LW = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
    logic [31:0] ADDR0 = '0, ADDR1 = '0, WDATA0 = '0, WDATA1 = '0;
    logic        GNT0, GNT1, RVALID0, RVALID1, DONE0, DONE1, MEM_REQ, MEM_WE;
    logic [31:0] RDATA, MEM_ADDR, MEM_WDATA;
    logic [1:0]  WIDX;
    logic [31:0] MEM_RDATA = '0;
    logic        MEM_ACK = 1'b0;

    cache_mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .RDATA(RDATA), .RVALID0(RVALID0), .RVALID1(RVALID1),
        .WIDX(WIDX), .DONE0(DONE0), .DONE1(DONE1),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return ((a - 32'h1230) >> 2) + 32'd1;
    endfunction

    typedef struct {
        logic        port;
        logic [1:0]  idx;
        logic [31:0] data;
    } sb_t;
    sb_t sb[$];
    int  grant_log[$];
    logic prev_g0 = 1'b0, prev_g1 = 1'b0;

    task automatic sb_push(input logic port, input logic [31:0] addr, input int n);
        sb_t e;
        logic [31:0] base;
        base = addr & ~32'hF;
        for (int k = 0; k < n; k++) begin
            e.port = port;
            e.idx  = 2'(k);
            e.data = mem_fn(base + 32'(4 * k));
            sb.push_back(e);
        end
    endtask

    // Memory model: ACK after mem_wait idle cycles of MEM_REQ, read data derived from address.
    int mem_wait = 0;
    bit force_ack = 1'b0;
    int wcnt = 0;
    always begin
        @(posedge CLK);
        #1;
        if (force_ack) begin
            MEM_ACK   = 1'b1;
            MEM_RDATA = 32'hFFFF_FFFF;
        end else if (MEM_REQ === 1'b1) begin
            if (wcnt >= mem_wait) begin
                MEM_ACK   = 1'b1;
                MEM_RDATA = MEM_WE ? 32'h0 : mem_fn(MEM_ADDR);
                wcnt      = 0;
            end else begin
                MEM_ACK = 1'b0;
                wcnt++;
            end
        end else begin
            MEM_ACK = 1'b0;
            wcnt    = 0;
        end
    end

    always @(negedge CLK) begin
        sb_t e;
        check("gnt_excl", GNT0 & GNT1, 0);
        check("rvalid_excl", RVALID0 & RVALID1, 0);
        if (RVALID0 || RVALID1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check("rd_word", {RVALID1, WIDX, RDATA}, {e.port, e.idx, e.data});
            end
        end
        if (GNT0 === 1'b1 && !prev_g0) grant_log.push_back(0);
        if (GNT1 === 1'b1 && !prev_g1) grant_log.push_back(1);
        prev_g0 = (GNT0 === 1'b1);
        prev_g1 = (GNT1 === 1'b1);
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {GNT0, GNT1, RVALID0, RVALID1, DONE0, DONE1, MEM_REQ, MEM_WE, WIDX}, 0);
        check({tag, "_mem"}, {MEM_ADDR, MEM_WDATA}, 0);
        check({tag, "_rdata"}, RDATA, 0);
    endtask

    task automatic wait_done(input logic port, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge CLK);
            seen = port ? DONE1 : DONE0;
        end
        check("done_seen", seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        int ndone;

        // Reset with a pending request and a stuck ACK, then release into a port 0 refill.
        RST = 1'b0; REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 32'h0000_1238; force_ack = 1'b1;
        repeat (2) @(negedge CLK);
        check_all_zero("reset");
        sb_push(0, 32'h1238, LW);
        force_ack = 1'b0;
        RST = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge CLK);
            check("t2_gnt0", GNT0, c <= 4);
            check("t2_memreq", MEM_REQ, c <= 4);
            if (c <= 4) check("t2_addr", MEM_ADDR, 32'h1230 + 32'(4 * (c - 1)));
            check("t2_rvalid0", RVALID0, c >= 2 && c <= 5);
            check("t2_done0", DONE0, c == 5);
            if (c == 5) REQ0 = 1'b0;
        end

        // Port 1 write-through with three wait states.
        mem_wait = 3;
        REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 32'h0000_0047; WDATA1 = 32'hDEAD_BEEF;
        for (int c = 1; c <= 6; c++) begin
            @(negedge CLK);
            check("t3_gnt1", GNT1, c <= 4);
            check("t3_memreq", {MEM_REQ, MEM_WE}, (c <= 4) ? 2'b11 : 2'b00);
            if (c <= 4) check("t3_addr_data", {MEM_ADDR, MEM_WDATA}, {32'h44, 32'hDEAD_BEEF});
            check("t3_done1", DONE1, c == 5);
            check("t3_rvalid1", RVALID1, 0);
            if (c == 5) REQ1 = 1'b0;
        end
        mem_wait = 0;

        // Both ports contend continuously after a reset: grants alternate starting with port 0.
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        grant_log.delete();
        WE0 = 1'b0; WE1 = 1'b0; ADDR0 = 32'h0000_1000; ADDR1 = 32'h0000_1104;
        sb_push(0, ADDR0, LW); sb_push(1, ADDR1, LW);
        sb_push(0, ADDR0, LW); sb_push(1, ADDR1, LW);
        REQ0 = 1'b1; REQ1 = 1'b1;
        ndone = 0;
        for (int i = 0; i < 60 && ndone < 4; i++) begin
            @(negedge CLK);
            if (grant_log.size() >= 4) begin
                REQ0 = 1'b0;
                REQ1 = 1'b0;
            end
            ndone += int'(DONE0) + int'(DONE1);
        end
        repeat (4) @(negedge CLK);
        check("t4_done_cnt", ndone, 4);
        check("t4_ngrant", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size() && i < 4; i++)
            check("t4_order", grant_log[i], i % 2);

        // Port 1 refill; port 0 requests mid-burst and port 1 drops REQ early.
        REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 32'h0000_2000;
        sb_push(1, ADDR1, LW);
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            if (c == 2) begin
                REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 32'h0000_3000;
                sb_push(0, ADDR0, LW);
            end
            if (c == 3) REQ1 = 1'b0;
            check("t5_gnt1", GNT1, c <= 4);
            check("t5_rvalid1", RVALID1, c >= 2 && c <= 5);
            check("t5_done1", DONE1, c == 5);
            check("t5_gnt0", GNT0, c >= 7);
        end
        REQ0 = 1'b0;
        wait_done(0, 20);
        repeat (2) @(negedge CLK);

        // Reset in the middle of a refill, then a fresh refill from beat 0.
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 32'h0000_4000;
        sb_push(0, ADDR0, 2);
        for (int c = 1; c <= 3; c++) @(negedge CLK);
        check("t6_addr_beat2", MEM_ADDR, 32'h4008);
        RST = 1'b0; REQ0 = 1'b0;
        @(negedge CLK);
        check_all_zero("t6_reset");
        RST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check("t6_no_done", {DONE0, DONE1, GNT0, GNT1}, 0);
        end
        REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 32'h0000_5008;
        sb_push(1, ADDR1, LW);
        @(negedge CLK);
        check("t6_fresh", {GNT1, MEM_REQ, MEM_ADDR}, {2'b11, 32'h5000});
        REQ1 = 1'b0;
        wait_done(1, 20);

        repeat (3) @(negedge CLK);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-port arbiter and burst sequencer sharing one main-memory bus between the instruction cache (port 0) and data cache (port 1). Each cache issues either a line refill (4-word burst read, critical-word-first not supported) or a single-word write-through; the block grants one requester at a time with round-robin fairness, sequences the memory handshake word by word and returns data plus a completion pulse to the owner. It sits between the cache controllers and the main-memory model.

## Interface
- LINE_WORDS, 4, words per cache line (burst length); power of two, 2..16
- ADDR_W, 32, byte address width
- DATA_W, 32, word width
- CLK  in  1  clock, all state changes on rising edge
- RST  in  1  reset, synchronous, active-low
- REQ0 / REQ1  in  1  request from port 0 / port 1; held high until that port's DONE
- WE0 / WE1  in  1  1 = single-word write, 0 = line refill; stable while REQ high
- ADDR0 / ADDR1  in  ADDR_W  byte address; stable while REQ high
- WDATA0 / WDATA1  in  DATA_W  write data; stable while REQ high
- GNT0 / GNT1  out  1  port owns the memory bus (one-hot or zero)
- RDATA  out  DATA_W  refill word, shared by both ports, qualified by RVALIDx
- RVALID0 / RVALID1  out  1  RDATA valid for that port, one pulse per word
- WIDX  out  log2(LINE_WORDS)  word index within line of current RDATA
- DONE0 / DONE1  out  1  one-cycle pulse, transaction complete
- MEM_REQ  out  1  memory access request, held until MEM_ACK
- MEM_WE  out  1  memory write enable
- MEM_ADDR  out  ADDR_W  word-aligned memory address
- MEM_WDATA  out  DATA_W  memory write data
- MEM_RDATA  in  DATA_W  memory read data, valid when MEM_ACK
- MEM_ACK  in  1  memory accepts write / returns read word this cycle

## Operation
- States: IDLE, READ, WRITE, FINISH.
- IDLE: if any REQ high, pick owner, set GNTx, latch WE/ADDR/WDATA, go READ (WE=0) or WRITE (WE=1). No REQ: stay.
- Arbitration: only one REQ -> that port. Both -> port not served last (LAST pointer). LAST updates on grant. Reset LAST = 1, so port 0 wins the first tie.
- READ: MEM_REQ=1, MEM_WE=0, MEM_ADDR = line base (latched ADDR with low log2(LINE_WORDS)+2 bits cleared) + 4*beat. Each MEM_ACK: capture MEM_RDATA, beat++. On ACK of beat LINE_WORDS-1 -> FINISH. Beat counter wraps to 0 in FINISH.
- WRITE: MEM_REQ=1, MEM_WE=1, MEM_ADDR = latched ADDR with bits [1:0] cleared, MEM_WDATA = latched WDATA. On MEM_ACK -> FINISH.
- FINISH: pulse DONEx, drop GNTx and MEM_REQ, return to IDLE. New arbitration starts the following cycle (one bubble between transactions).
- Owner dropping REQ mid-transaction: ignored; transaction runs to completion, DONE still pulses.
- Non-owner REQ during a transaction: held off (GNT low) until IDLE.
- MEM_ACK in IDLE or FINISH: ignored.
- Reset (RST=0 at edge), including mid-burst: state IDLE, beat 0, LAST 1, every output 0 (GNT*, RVALID*, DONE*, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, RDATA, WIDX). Partial burst discarded; no DONE.

## Timing
- All outputs registered.
- Cycle 0 REQ sampled in IDLE -> cycle 1 GNTx and MEM_REQ high with first MEM_ADDR.
- Read word k: MEM_ACK at cycle t -> RDATA, RVALIDx=1, WIDX=k at t+1. MEM_ADDR advances to next word at t+1.
- Zero-wait memory (ACK every cycle from cycle 1): words at cycles 2..LINE_WORDS+1; DONEx with last RVALIDx in cycle LINE_WORDS+1; GNTx low same cycle; next grant earliest cycle LINE_WORDS+3.
- Write with ACK at cycle 1: DONEx at cycle 2, no RVALID.
- MEM_REQ never deasserts between beats of one burst; wait states (ACK low) hold MEM_ADDR stable.

## Test plan
- Reset: RST=0 two cycles with REQ0=1 and MEM_ACK=1 -> all outputs 0; RST=1 -> GNT0 one cycle later.
- Refill port 0, ADDR0=0x0000_1238, zero-wait memory returning 1,2,3,4 -> MEM_ADDR 0x1230,0x1234,0x1238,0x123C; RVALID0 cycles 2-5 with RDATA 1..4, WIDX 0..3; DONE0 cycle 5.
- Write-through port 1, ADDR1=0x0000_0047, WDATA1=0xDEADBEEF, ACK after 3 wait cycles -> MEM_WE=1, MEM_ADDR=0x44, MEM_WDATA=0xDEADBEEF held 4 cycles; DONE1 one cycle after ACK.
- REQ0 and REQ1 raised together after reset, both held, repeated -> grants alternate 0,1,0,1; GNT0 and GNT1 never both high.
- Mid-burst: port 1 refill, REQ0 asserted at beat 1, REQ1 dropped at beat 2 -> port 1 burst finishes with 4 RVALID1 and DONE1; GNT0 one cycle after FINISH.
- Reset asserted at beat 2 of a refill -> no DONE, outputs 0 next cycle; fresh request afterwards completes normally from beat 0.
